ps2_host_tx: RTL
================

# ps2_host_tx

Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to a keyboard or mouse over the open-drain PS2_CLK/PS2_DAT lines, the opposite direction to the board's device-to-host scan-code receive path. It performs the request-to-send sequence, shifts data on device-generated clock edges, checks the device ACK, and reports done or error. It sits between the system logic and the PS/2 pad tristates, sharing the lines with the receiver. The receiver must ignore the lines while `tx_ready` is 0.

## Interface
Parameters:
- INHIBIT_CYCLES, 6000: clock-low inhibit length; 120 µs at 50 MHz.
- RTS_CYCLES, 100: start-bit setup with clock and data both held low, before the clock is released.
- TIMEOUT_CYCLES, 750000: watchdog limit between device clock falling edges; 15 ms.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- RESET  in  1  asynchronous, active-high reset.
- tx_data  in  8  command byte.
- tx_valid  in  1  request; accepted when `tx_valid & tx_ready`.
- tx_ready  out  1  high only in IDLE.
- tx_done  out  1  one-cycle pulse: frame sent and ACK received.
- tx_error  out  1  one-cycle pulse: timeout or missing ACK.
- ps2_clk_in  in  1  raw PS2_CLK pad level (asynchronous).
- ps2_dat_in  in  1  raw PS2_DAT pad level (asynchronous).
- ps2_clk_oe  out  1  1 = pull PS2_CLK low; 0 = release.
- ps2_dat_oe  out  1  1 = pull PS2_DAT low; 0 = release.

## Operation
- Inputs pass through 2-FF synchronizers. A falling edge (`fall`) is previous-sampled clock 1 and current 0.
- State flow is IDLE → INHIBIT → RTS → SEND → ACK → WAIT_IDLE → IDLE.
- **IDLE**
  - Both oe are 0.
  - On accept, latch the frame shift register {stop=1, parity=~^tx_data, tx_data} and go to INHIBIT.
- **INHIBIT**
  - `ps2_clk_oe`=1 for INHIBIT_CYCLES cycles.
  - Then set `ps2_dat_oe`=1 (start bit) and go to RTS.
- **RTS**
  - Both oe stay at 1 for RTS_CYCLES cycles.
  - Then release `ps2_clk_oe`, clear the bit counter and watchdog, and go to SEND.
- **SEND**
  - On each `fall`, present the next bit LSB-first: D0..D7, parity, stop.
  - `ps2_dat_oe` = ~bit. The stop bit releases data.
  - After the 10th `fall` (stop presented), go to ACK.
- **ACK**
  - On the next `fall`, sample synchronized data.
  - 0 → go to WAIT_IDLE.
  - 1 → pulse `tx_error` and go to IDLE.
- **WAIT_IDLE**
  - When synchronized clock and data are both 1, pulse `tx_done` and go to IDLE.
- **Watchdog**
  - Counts in SEND, ACK and WAIT_IDLE, and is cleared on every `fall`.
  - When it reaches TIMEOUT_CYCLES, release both lines, pulse `tx_error` and go to IDLE.
- **Event rules**
  - `tx_done` and `tx_error` never assert together.
  - `tx_valid` while not ready is ignored; there is no queueing.
  - `tx_data` is only sampled at accept.
- **Reset**
  - RESET mid-frame forces IDLE asynchronously.
  - Both oe drop to 0 immediately and no done/error pulse is produced.

## Timing
- Reset values:
  - `tx_ready`=1.
  - `tx_done`, `tx_error`, `ps2_clk_oe`, `ps2_dat_oe` all 0.
  - Counters 0.
- Accept to `ps2_clk_oe`=1: 1 cycle.
- Clock held low for exactly INHIBIT_CYCLES+RTS_CYCLES cycles.
- `ps2_dat_oe` rises INHIBIT_CYCLES cycles after `ps2_clk_oe`.
- Bit change latency: `ps2_dat_oe` updates 3 cycles after the pad falling edge (2 sync + 1 register), well inside the device's ~40 µs low phase.
- `tx_done`/`tx_error` pulses are registered. `tx_ready` returns to 1 in the same cycle as the pulse.
- All outputs are registered; no combinational path from inputs.

## Configuration
- Macro `PS2_TX_GLITCH_FILTER_EN`:
  - Defined: the synchronized clock feeds an 8-cycle stability filter. The filtered level changes only after 8 consecutive equal samples, so `fall` latency becomes 11 cycles and pulses shorter than 8 cycles are rejected.
  - Undefined: `fall` comes directly from the synchronizer with 3-cycle latency; every edge counts.

## Test plan
- **ACK path:** bench uses a device model clocking at 12.5 kHz that ACKs. Send 0xED → bits presented are 1,0,1,1,0,1,1,1, parity 1, stop 1. Model receives 0xED with parity OK. `tx_done` pulses once, `tx_error` stays 0.
- **Hold-time check:** send 0x00 with INHIBIT_CYCLES=6000, RTS_CYCLES=100 → `ps2_clk_oe` high for exactly 6100 cycles and `ps2_dat_oe` high from cycle 6000. Parity bit is 1.
- **Timeout:** TIMEOUT_CYCLES=1000 and the device never clocks → `tx_error` exactly 1000 cycles after clock release. Both oe are 0 and `tx_ready` is 1.
- **No ACK:** model leaves data high on the 11th clock → `tx_error` pulses and `tx_done` never asserts.
- **Reset mid-frame:** RESET asserted mid-frame after the 4th `fall` → both oe are 0 asynchronously and `tx_ready`=1. A following 0xFF send completes with `tx_done`.
- **Glitch rejection:** with the macro defined, a 3-cycle low glitch on the clock during SEND → no bit advance and the frame still completes correctly.

Source files
------------

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: request-to-send, bit shifting on device clock edges, ACK check.
// Optional `PS2_TX_GLITCH_FILTER_EN adds an 8-sample stability filter on the synchronized PS/2 clock.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int RTS_CYCLES     = 100,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);

    localparam int PH_W = $clog2(INHIBIT_CYCLES + RTS_CYCLES + 1);
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [PH_W-1:0] INHIBIT_LAST = PH_W'(INHIBIT_CYCLES - 1);
    localparam logic [PH_W-1:0] RTS_LAST     = PH_W'(RTS_CYCLES - 1);
    localparam logic [WD_W-1:0] WDOG_LAST    = WD_W'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_INHIBIT   = 3'd1;
    localparam logic [2:0] ST_RTS       = 3'd2;
    localparam logic [2:0] ST_SEND      = 3'd3;
    localparam logic [2:0] ST_ACK       = 3'd4;
    localparam logic [2:0] ST_WAIT_IDLE = 3'd5;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

    logic clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q, clk_prev_q;
    logic clk_lvl_s, fall_s;

    // Two-flop synchronizers for both pads; lines idle high.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
        end else begin
            clk_s1_q <= ps2_clk_in;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= ps2_dat_in;
            dat_s2_q <= dat_s1_q;
        end
    end

`ifdef PS2_TX_GLITCH_FILTER_EN
    logic       filt_q;
    logic [2:0] filt_cnt_q;

    // Filtered level flips only after 8 consecutive samples disagree with it.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            filt_q     <= 1'b1;
            filt_cnt_q <= 3'd0;
        end else if (clk_s2_q != filt_q) begin
            if (filt_cnt_q == 3'd7) begin
                filt_q     <= clk_s2_q;
                filt_cnt_q <= 3'd0;
            end else begin
                filt_cnt_q <= filt_cnt_q + 3'd1;
            end
        end else begin
            filt_cnt_q <= 3'd0;
        end
    end

    assign clk_lvl_s = filt_q;
`else
    assign clk_lvl_s = clk_s2_q;
`endif

    // Previous clock level for falling-edge detection.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            clk_prev_q <= 1'b1;
        end else begin
            clk_prev_q <= clk_lvl_s;
        end
    end

    assign fall_s = clk_prev_q & ~clk_lvl_s;

    logic [2:0]      state_q, state_d;
    logic [PH_W-1:0] phase_q, phase_d;
    logic [WD_W-1:0] wdog_q, wdog_d;
    logic [3:0]      bit_q, bit_d;
    logic [9:0]      shift_q, shift_d;
    logic            clk_oe_q, clk_oe_d;
    logic            dat_oe_q, dat_oe_d;
    logic            done_q, done_d;
    logic            error_q, error_d;
    logic            ready_q, ready_d;
    logic            timeout_s;

    assign timeout_s = ~fall_s & (wdog_q == WDOG_LAST);

    // Next-state logic for the transmit sequencer.
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        wdog_d   = wdog_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        clk_oe_d = clk_oe_q;
        dat_oe_d = dat_oe_q;
        done_d   = 1'b0;
        error_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                if (tx_valid && ready_q) begin
                    shift_d  = {1'b1, odd_parity(tx_data), tx_data};
                    phase_d  = {PH_W{1'b0}};
                    clk_oe_d = 1'b1;
                    state_d  = ST_INHIBIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_INHIBIT: begin
                if (phase_q == INHIBIT_LAST) begin
                    phase_d  = {PH_W{1'b0}};
                    dat_oe_d = 1'b1;
                    state_d  = ST_RTS;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            ST_RTS: begin
                if (phase_q == RTS_LAST) begin
                    phase_d  = {PH_W{1'b0}};
                    clk_oe_d = 1'b0;
                    bit_d    = 4'd0;
                    wdog_d   = {WD_W{1'b0}};
                    state_d  = ST_SEND;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            ST_SEND, ST_ACK, ST_WAIT_IDLE: begin
                if (fall_s) begin
                    wdog_d = {WD_W{1'b0}};
                end else begin
                    wdog_d = wdog_q + WD_W'(1);
                end
                if (timeout_s) begin
                    wdog_d   = {WD_W{1'b0}};
                    clk_oe_d = 1'b0;
                    dat_oe_d = 1'b0;
                    error_d  = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    case (state_q)
                        ST_SEND: begin
                            if (fall_s) begin
                                dat_oe_d = ~shift_q[0];
                                shift_d  = {1'b0, shift_q[9:1]};
                                if (bit_q == 4'd9) begin
                                    bit_d   = 4'd0;
                                    state_d = ST_ACK;
                                end else begin
                                    bit_d = bit_q + 4'd1;
                                end
                            end else begin
                                bit_d = bit_q;
                            end
                        end
                        ST_ACK: begin
                            if (fall_s) begin
                                if (dat_s2_q == 1'b0) begin
                                    state_d = ST_WAIT_IDLE;
                                end else begin
                                    dat_oe_d = 1'b0;
                                    error_d  = 1'b1;
                                    state_d  = ST_IDLE;
                                end
                            end else begin
                                state_d = ST_ACK;
                            end
                        end
                        ST_WAIT_IDLE: begin
                            if (clk_lvl_s && dat_s2_q) begin
                                wdog_d  = {WD_W{1'b0}};
                                done_d  = 1'b1;
                                state_d = ST_IDLE;
                            end else begin
                                state_d = ST_WAIT_IDLE;
                            end
                        end
                        default: begin
                            state_d = ST_IDLE;
                        end
                    endcase
                end
            end
            default: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
        ready_d = (state_d == ST_IDLE);
    end

    // Sequencer state and registered outputs; reset drops both pad drivers at once.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state_q  <= ST_IDLE;
            phase_q  <= {PH_W{1'b0}};
            wdog_q   <= {WD_W{1'b0}};
            bit_q    <= 4'd0;
            shift_q  <= 10'd0;
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            wdog_q   <= wdog_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            clk_oe_q <= clk_oe_d;
            dat_oe_q <= dat_oe_d;
            done_q   <= done_d;
            error_q  <= error_d;
            ready_q  <= ready_d;
        end
    end

    assign tx_ready   = ready_q;
    assign tx_done    = done_q;
    assign tx_error   = error_q;
    assign ps2_clk_oe = clk_oe_q;
    assign ps2_dat_oe = dat_oe_q;

endmodule
